// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - shared register-file write port arbiter with RAW scoreboard
// Define WB_ROUND_ROBIN_EN for round-robin grants; default build uses fixed lowest-index priority.
module regfile_wb_arbiter #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 5,
  parameter int NUM_REQ       = 2
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [NUM_REQ-1:0]               req_valid,
  input  logic [NUM_REQ*ADDRESS_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_data,
  output logic [NUM_REQ-1:0]               req_ready,
  output logic                             wb_we,
  output logic [ADDRESS_WIDTH-1:0]         wb_addr,
  output logic [DATA_WIDTH-1:0]            wb_data,
  input  logic                             issue_valid,
  input  logic [ADDRESS_WIDTH-1:0]         issue_addr,
  input  logic [ADDRESS_WIDTH-1:0]         rs1_addr,
  input  logic [ADDRESS_WIDTH-1:0]         rs2_addr,
  output logic                             hazard,
  output logic [2**ADDRESS_WIDTH-1:0]      pending
);

  localparam int NREG = 2**ADDRESS_WIDTH;

  logic [NUM_REQ-1:0]       grant;
  logic                     accept;
  logic [ADDRESS_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0]    sel_data;

  logic                     wb_we_q;
  logic [ADDRESS_WIDTH-1:0] wb_addr_q;
  logic [DATA_WIDTH-1:0]    wb_data_q;
  logic [NREG-1:0]          pending_q, pending_d;

`ifdef WB_ROUND_ROBIN_EN
  localparam int IDXW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [IDXW-1:0] ptr_q, ptr_d;
  logic [IDXW-1:0] cand;
  logic            found;

  // Search begins just after the last winner, wrapping modulo NUM_REQ.
  always_comb begin
    grant = '0;
    ptr_d = ptr_q;
    found = 1'b0;
    cand  = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = IDXW'((int'(ptr_q) + k) % NUM_REQ);
      if (!found && req_valid[cand]) begin
        grant[cand] = 1'b1;
        ptr_d       = cand;
        found       = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_q <= IDXW'(NUM_REQ - 1);
    end else begin
      ptr_q <= ptr_d;
    end
  end
`else
  always_comb begin
    grant = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_valid[i]) begin
        grant    = '0;
        grant[i] = 1'b1;
      end
    end
  end
`endif

  assign accept    = |req_valid;
  assign req_ready = grant;

  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      sel_addr = sel_addr | ({ADDRESS_WIDTH{grant[i]}} & req_addr[i*ADDRESS_WIDTH +: ADDRESS_WIDTH]);
      sel_data = sel_data | ({DATA_WIDTH{grant[i]}} & req_data[i*DATA_WIDTH +: DATA_WIDTH]);
    end
  end

  // x0 writes are consumed but never reach the register file.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wb_we_q   <= 1'b0;
      wb_addr_q <= '0;
      wb_data_q <= '0;
    end else begin
      wb_we_q <= accept && (sel_addr != '0);
      if (accept) begin
        wb_addr_q <= sel_addr;
        wb_data_q <= sel_data;
      end
    end
  end

  // Clear applied before set so an issue colliding with a write keeps the bit.
  always_comb begin
    pending_d = pending_q;
    if (wb_we_q) begin
      pending_d[wb_addr_q] = 1'b0;
    end
    if (issue_valid && (issue_addr != '0)) begin
      pending_d[issue_addr] = 1'b1;
    end
    pending_d[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending_q <= '0;
    end else begin
      pending_q <= pending_d;
    end
  end

  assign wb_we   = wb_we_q;
  assign wb_addr = wb_addr_q;
  assign wb_data = wb_data_q;
  assign pending = pending_q;
  assign hazard  = pending_q[rs1_addr] | pending_q[rs2_addr];

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb/tb_regfile_wb_arbiter.sv - self-checking bench for regfile_wb_arbiter
// Reference model follows WB_ROUND_ROBIN_EN the same way the design does.
module tb_regfile_wb_arbiter;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int N  = 2;
  localparam int NR = 32;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    req_valid;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    req_ready;
  logic            wb_we;
  logic [AW-1:0]   wb_addr;
  logic [DW-1:0]   wb_data;
  logic            issue_valid;
  logic [AW-1:0]   issue_addr;
  logic [AW-1:0]   rs1_addr;
  logic [AW-1:0]   rs2_addr;
  logic            hazard;
  logic [NR-1:0]   pending;

  regfile_wb_arbiter #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .NUM_REQ(N)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_addr(req_addr),
    .req_data(req_data), .req_ready(req_ready), .wb_we(wb_we), .wb_addr(wb_addr),
    .wb_data(wb_data), .issue_valid(issue_valid), .issue_addr(issue_addr),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .hazard(hazard), .pending(pending)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  int            mptr;
  logic          mwe;
  logic [AW-1:0] maddr;
  logic [DW-1:0] mdata;
  logic [NR-1:0] mpend;
  int            last_g;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) passes++;
    else $error("FAIL %s got %h expected %h", tag, got, exp);
  endtask

  function automatic int grant_of(input logic [N-1:0] v);
`ifdef WB_ROUND_ROBIN_EN
    for (int k = 1; k <= N; k++) begin
      if (v[(mptr + k) % N]) return (mptr + k) % N;
    end
`else
    for (int i = 0; i < N; i++) begin
      if (v[i]) return i;
    end
`endif
    return -1;
  endfunction

  task automatic model_reset();
    mptr  = N - 1;
    mwe   = 1'b0;
    maddr = '0;
    mdata = '0;
    mpend = '0;
  endtask

  // Called just after a rising edge with the next cycle's inputs already driven.
  task automatic cycle();
    int g;
    logic [N-1:0] er;
    @(negedge clk);
    g  = grant_of(req_valid);
    er = '0;
    if (g >= 0) er[g] = 1'b1;
    chk("req_ready", 64'(req_ready), 64'(er));
    chk("wb_we", 64'(wb_we), 64'(mwe));
    chk("wb_addr", 64'(wb_addr), 64'(maddr));
    chk("wb_data", 64'(wb_data), 64'(mdata));
    chk("pending", 64'(pending), 64'(mpend));
    chk("hazard", 64'(hazard), 64'(mpend[rs1_addr] | mpend[rs2_addr]));
    @(posedge clk);
    if (mwe) mpend[maddr] = 1'b0;
    if (issue_valid && issue_addr != 0) mpend[issue_addr] = 1'b1;
    if (g >= 0) begin
      maddr = req_addr[g*AW +: AW];
      mdata = req_data[g*DW +: DW];
      mwe   = (maddr != 0);
      mptr  = g;
    end else begin
      mwe = 1'b0;
    end
    last_g = g;
    #1;
  endtask

  task automatic set_req(input int i, input logic v, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_valid[i]         = v;
    req_addr[i*AW +: AW] = a;
    req_data[i*DW +: DW] = d;
  endtask

  initial begin
    reset       = 1'b1;
    req_valid   = '0;
    req_addr    = '0;
    req_data    = '0;
    issue_valid = 1'b0;
    issue_addr  = '0;
    rs1_addr    = '0;
    rs2_addr    = '0;
    last_g      = -1;
    model_reset();
    #12;
    chk("reset_wb_we", 64'(wb_we), 64'd0);
    chk("reset_wb_addr", 64'(wb_addr), 64'd0);
    chk("reset_wb_data", 64'(wb_data), 64'd0);
    chk("reset_pending", 64'(pending), 64'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    // Single write
    set_req(0, 1'b1, 5'd5, 32'hDEADBEEF);
    cycle();
    set_req(0, 1'b0, 5'd0, 32'h0);
    #1;
    chk("single_we", 64'(wb_we), 64'd1);
    chk("single_addr", 64'(wb_addr), 64'd5);
    chk("single_data", 64'(wb_data), 64'hDEADBEEF);
    cycle();
    cycle();

    // Contention
    set_req(0, 1'b1, 5'd1, 32'h11111111);
    set_req(1, 1'b1, 5'd2, 32'h22222222);
    repeat (4) cycle();
    req_valid = '0;
    cycle();

    // x0 write, then contention
    set_req(1, 1'b1, 5'd0, 32'h1234);
    cycle();
    req_valid = '0;
    cycle();
    chk("x0_no_we", 64'(wb_we), 64'd0);
    set_req(0, 1'b1, 5'd3, 32'h33);
    set_req(1, 1'b1, 5'd4, 32'h44);
    cycle();
    req_valid = '0;
    cycle();

    // Scoreboard
    issue_valid = 1'b1; issue_addr = 5'd7; rs1_addr = 5'd7; rs2_addr = 5'd0;
    cycle();
    issue_valid = 1'b0;
    cycle();
    set_req(0, 1'b1, 5'd7, 32'h77);
    cycle();
    req_valid = '0;
    cycle();
    cycle();
    chk("sb_hazard_clear", 64'(hazard), 64'd0);

    // Collision on register 9
    rs1_addr = 5'd9;
    set_req(0, 1'b1, 5'd9, 32'h99);
    cycle();
    req_valid = '0; issue_valid = 1'b1; issue_addr = 5'd9;
    cycle();
    issue_valid = 1'b0;
    cycle();
    chk("collide_keep", 64'(pending[9]), 64'd1);
    set_req(0, 1'b1, 5'd9, 32'h9A);
    cycle();
    req_valid = '0;
    cycle();
    cycle();
    chk("collide_clear", 64'(pending[9]), 64'd0);

    // Reset mid-operation
    issue_valid = 1'b1; issue_addr = 5'd3;
    cycle();
    issue_addr = 5'd7;
    cycle();
    issue_valid = 1'b0;
    set_req(1, 1'b1, 5'd4, 32'h4444);
    cycle();
    req_valid = '0;
    chk("pre_reset_pending", 64'(pending), 64'h88);
    #2 reset = 1'b1;
    #1;
    chk("async_wb_we", 64'(wb_we), 64'd0);
    chk("async_pending", 64'(pending), 64'd0);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    set_req(0, 1'b1, 5'd10, 32'hA);
    set_req(1, 1'b1, 5'd11, 32'hB);
    #1;
    chk("post_reset_grant", 64'(req_ready), 64'd1);
    cycle();
    req_valid = '0;
    last_g = -1;

    // Randomized traffic; requesters hold until accepted
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!req_valid[i] || last_g == i)
          set_req(i, 1'($urandom_range(0, 1)), AW'($urandom_range(0, NR - 1)), $urandom);
      end
      issue_valid = ($urandom_range(0, 3) == 0);
      issue_addr  = AW'($urandom_range(0, NR - 1));
      rs1_addr    = AW'($urandom_range(0, NR - 1));
      rs2_addr    = AW'($urandom_range(0, NR - 1));
      cycle();
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
